ca_sequencer: RTL and testbench

Controller for the 1-D cellular-automaton datapath. It owns the generation register, the row pointer into the image BRAM and the active rule. It paces generations from a step counter and commits each generation to the frame buffer only during vertical blanking. Two board buttons change the rule, and any rule change restarts the pattern from the seed. The block sits between the `vga_sync` blanking output, the combinational `automaton` block and the image BRAM write port, in the `px_clk` domain.

---
 rtl/ca_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_ca_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ca_sequencer.sv
// ca_sequencer: controller for the 1-D cellular-automaton datapath.
//   Owns the generation register, the image BRAM row pointer and the
//   active rule. Generations are paced by a step counter and committed
//   to the frame buffer only while vblank is high. Two debounced buttons
//   step the rule up/down; any accepted press restarts from SEED.
//
// Ports:
//   clk, rst_n        pixel clock, async active-low reset
//   sw1, sw2          raw buttons (sw1: rule+1, sw2: rule-1)
//   vblank            vertical blanking from vga_sync
//   ca_next [WIDTH]   automaton result for ca_cur
//   ca_cur  [WIDTH]   current generation (automaton input)
//   rule    [8]       active rule (automaton input)
//   wr_en             BRAM write strobe, one cycle per generation
//   wr_row  [7]       BRAM write row
//   wr_data [WIDTH]   BRAM write data (== ca_cur)
//   gen_count [16]    generations since last restart, wraps

// Per-button front end: 2-flop synchronizer, level debouncer and
// rising-edge detector producing a one-cycle press.
module ca_btn_deb #(
  parameter int DEB_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          lvl_prev_q;

  // Count consecutive samples that disagree with the accepted level; any
  // agreeing sample restarts the count, so only a stable level is taken.
  always_comb begin
    cnt_d = '0;
    lvl_d = lvl_q;
    if (sync_q[1] != lvl_q) begin
      if (cnt_q == CNT_MAX) lvl_d = sync_q[1];
      else                  cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      lvl_q      <= 1'b0;
      lvl_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], btn_i};
      cnt_q      <= cnt_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_q;
    end
  end

  assign press_o = lvl_q & ~lvl_prev_q;
endmodule

module ca_sequencer #(
  parameter int              WIDTH       = 80,
  parameter int              ROWS        = 60,
  parameter int              STEP_CYCLES = 524288,
  parameter int              DEB_CYCLES  = 65536,
  parameter logic [WIDTH-1:0] SEED       = WIDTH'(1) << (WIDTH / 2),
  parameter logic [7:0]      RULE_INIT   = 8'd30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sw1,
  input  logic             sw2,
  input  logic             vblank,
  input  logic [WIDTH-1:0] ca_next,
  output logic [WIDTH-1:0] ca_cur,
  output logic [7:0]       rule,
  output logic             wr_en,
  output logic [6:0]       wr_row,
  output logic [WIDTH-1:0] wr_data,
  output logic [15:0]      gen_count
);
  localparam int NUM_BTN = 2;
  localparam int SCW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [SCW-1:0] STEP_MAX = SCW'(STEP_CYCLES - 1);
  localparam logic [6:0]     ROW_MAX  = 7'(ROWS - 1);

  typedef enum logic [2:0] {
    S_SEED, S_WAIT_TICK, S_WAIT_VB, S_WRITE, S_ADVANCE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ca_q, ca_d;
  logic [6:0]       row_q, row_d;
  logic [15:0]      gen_q, gen_d;
  logic [7:0]       rule_q, rule_d;
  logic [SCW-1:0]   cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             restart_q, restart_d;
  logic             wr_en_q, wr_en_d;
  logic             vb_q;

  // ---- button front ends: bit 0 = sw1 (up), bit 1 = sw2 (down) ----
  logic [NUM_BTN-1:0] btn_raw, btn_press;
  assign btn_raw = {sw2, sw1};

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    ca_btn_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_i  (btn_raw[b]),
      .press_o(btn_press[b])
    );
  end

  always_comb begin
    state_d   = state_q;
    ca_d      = ca_q;
    row_d     = row_q;
    gen_d     = gen_q;
    rule_d    = rule_q;
    restart_d = restart_q;
    cnt_d     = (cnt_q == STEP_MAX) ? '0 : cnt_q + SCW'(1);
    // One-deep tick: a wrap while the flag is already set is lost.
    tick_d    = tick_q | (cnt_q == STEP_MAX);

    unique case (state_q)
      S_SEED: begin
        ca_d      = SEED;
        row_d     = '0;
        gen_d     = '0;
        cnt_d     = '0;
        tick_d    = 1'b0;
        restart_d = 1'b0;
        state_d   = S_WAIT_VB;
      end
      S_WAIT_TICK: begin
        if (tick_q) begin
          tick_d  = 1'b0;
          state_d = S_WAIT_VB;
        end
      end
      // vblank is registered, so a write lands two cycles after it rises
      // and two cycles after a consumed tick when blanking is already on.
      S_WAIT_VB: if (vb_q) state_d = S_WRITE;
      S_WRITE:   state_d = restart_q ? S_SEED : S_ADVANCE;
      S_ADVANCE: begin
        ca_d    = ca_next;
        row_d   = (row_q == ROW_MAX) ? '0 : row_q + 7'd1;
        gen_d   = gen_q + 16'd1;
        state_d = S_WAIT_TICK;
      end
      default: state_d = S_SEED;
    endcase

    // A pending restart preempts everything except an in-flight write,
    // which has already been committed to the BRAM port.
    if (restart_q && state_q != S_WRITE && state_q != S_SEED)
      state_d = S_SEED;

    unique case (btn_press)
      2'b01:   rule_d = rule_q + 8'd1;
      2'b10:   rule_d = rule_q - 8'd1;
      default: rule_d = rule_q;
    endcase
    // Set wins over SEED's clear so a press landing in SEED is not lost.
    if (|btn_press) restart_d = 1'b1;

    wr_en_d = (state_d == S_WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_SEED;
      ca_q      <= SEED;
      row_q     <= '0;
      gen_q     <= '0;
      rule_q    <= RULE_INIT;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      restart_q <= 1'b0;
      wr_en_q   <= 1'b0;
      vb_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ca_q      <= ca_d;
      row_q     <= row_d;
      gen_q     <= gen_d;
      rule_q    <= rule_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      restart_q <= restart_d;
      wr_en_q   <= wr_en_d;
      vb_q      <= vblank;
    end
  end

  assign ca_cur    = ca_q;
  assign wr_data   = ca_q;
  assign wr_row    = row_q;
  assign rule      = rule_q;
  assign wr_en     = wr_en_q;
  assign gen_count = gen_q;
endmodule

// File: tb/tb_ca_sequencer.sv
module tb_ca_sequencer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sw1 = 1'b0, sw2 = 1'b0, vblank = 1'b1;
  logic [W-1:0] ca_next, ca_cur, wr_data;
  logic [7:0]   rule;
  logic         wr_en;
  logic [6:0]   wr_row;
  logic [15:0]  gen_count;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ca_sequencer #(
    .WIDTH(W), .ROWS(4), .STEP_CYCLES(16), .DEB_CYCLES(4),
    .SEED(8'h10), .RULE_INIT(8'd30)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw1(sw1), .sw2(sw2), .vblank(vblank),
    .ca_next(ca_next), .ca_cur(ca_cur), .rule(rule), .wr_en(wr_en),
    .wr_row(wr_row), .wr_data(wr_data), .gen_count(gen_count)
  );

  // Automaton in the loop: cells outside the row read as 0,
  // neighbourhood index {left=bit i+1, centre, right=bit i-1}.
  always_comb begin
    logic [W+1:0] pad;
    pad = {1'b0, ca_cur, 1'b0};
    ca_next = '0;
    for (int i = 0; i < W; i++) ca_next[i] = rule[pad[i+:3]];
  end

  typedef struct {
    logic [6:0]  row;
    logic [7:0]  data;
    logic [15:0] gen;
  } wr_vec_t;

  typedef struct {
    logic       s1;
    logic       s2;
    logic       press;   // 0: short glitch that must be rejected
    logic [7:0] exp_rule;
  } btn_vec_t;

  wr_vec_t  wtab[4];
  btn_vec_t btab[5];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_write(input int bound, output bit got);
    int n = 0;
    got = 1'b0;
    while (!got && n < bound) begin
      @(negedge clk);
      n++;
      if (wr_en) got = 1'b1;
    end
    if (!got) begin
      nvec++;
      nerr++;
      $display("FAIL write_timeout: no wr_en within %0d cycles", bound);
    end
  endtask

  task automatic chk_write(input string nm, input logic [6:0] row,
                           input logic [7:0] data, input logic [15:0] gen);
    chk({nm, "_row"}, 16'(wr_row), 16'(row));
    chk({nm, "_data"}, 16'(wr_data), 16'(data));
    chk({nm, "_gen"}, gen_count, gen);
  endtask

  task automatic apply_btn(input btn_vec_t v);
    bit got;
    int n;
    if (!v.press) begin
      sw1 = v.s1; sw2 = v.s2;
      repeat (3) @(negedge clk);
      sw1 = 1'b0; sw2 = 1'b0;
      repeat (12) @(negedge clk);
      chk("glitch_rule", 16'(rule), 16'(v.exp_rule));
    end else begin
      // Make sure the seed generation has already been advanced so the
      // restart is visible as a return to row 0 / gen 0 / seed data.
      n = 0;
      while (gen_count == 16'd0 && n < 60) begin
        @(negedge clk);
        n++;
      end
      if (gen_count == 16'd0) begin
        nvec++; nerr++;
        $display("FAIL pre_press_gen: got 0x0, want nonzero");
      end
      sw1 = v.s1; sw2 = v.s2;
      // Press is accepted and rule/restart registered by the 7th edge;
      // a write in that window may still be the old generation.
      repeat (7) @(negedge clk);
      wait_write(40, got);
      if (got) begin
        chk_write("restart_seed", 7'd0, 8'h10, 16'd0);
        chk("press_rule", 16'(rule), 16'(v.exp_rule));
      end
      sw1 = 1'b0; sw2 = 1'b0;
      repeat (10) @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit got;
    int nw;
    btn_vec_t bv;

    wtab[0] = '{7'd1, 8'h38, 16'd1};
    wtab[1] = '{7'd2, 8'h64, 16'd2};
    wtab[2] = '{7'd3, 8'hDE, 16'd3};
    wtab[3] = '{7'd0, 8'h91, 16'd4};

    btab[0] = '{1'b1, 1'b0, 1'b0, 8'd30};   // 3-cycle glitch
    btab[1] = '{1'b1, 1'b0, 1'b1, 8'd31};   // sw1 press
    btab[2] = '{1'b0, 1'b1, 1'b1, 8'd30};   // sw2 press
    btab[3] = '{1'b0, 1'b1, 1'b1, 8'd255};  // 0 -> 255 wrap
    btab[4] = '{1'b1, 1'b1, 1'b1, 8'd255};  // both: unchanged, restart

    // 1. reset values and seed write on cycle 2
    repeat (3) @(negedge clk);
    chk("rst_wr_en", 16'(wr_en), 16'd0);
    chk("rst_ca_cur", 16'(ca_cur), 16'h10);
    chk("rst_rule", 16'(rule), 16'd30);
    chk("rst_row", 16'(wr_row), 16'd0);
    chk("rst_gen", gen_count, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("seed_c1_wr_en", 16'(wr_en), 16'd0);
    @(negedge clk);
    chk("seed_c2_wr_en", 16'(wr_en), 16'd1);
    chk_write("seed", 7'd0, 8'h10, 16'd0);

    // 2. steady run, rule 30
    for (int k = 0; k < 4; k++) begin
      wait_write(40, got);
      if (got) chk_write($sformatf("steady%0d", k), wtab[k].row, wtab[k].data, wtab[k].gen);
    end

    // 3. held generation across several ticks
    vblank = 1'b0;
    nw = 0;
    repeat (60) begin
      @(negedge clk);
      if (wr_en) nw++;
    end
    chk("held_no_write", 16'(nw), 16'd0);
    chk("held_gen", gen_count, 16'd5);
    vblank = 1'b1;
    @(negedge clk);
    chk("held_rise_c1", 16'(wr_en), 16'd0);
    @(negedge clk);
    chk("held_rise_c2", 16'(wr_en), 16'd1);
    chk_write("held", 7'd1, 8'hFB, 16'd5);
    nw = 0;
    repeat (3) begin
      @(negedge clk);
      if (wr_en) nw++;
    end
    chk("held_single", 16'(nw), 16'd0);
    wait_write(40, got);
    if (got) chk_write("post_held", 7'd2, 8'h82, 16'd6);

    // 4/5. debounce, rule stepping, wrap and simultaneous press
    for (int k = 0; k < 5; k++) begin
      if (k == 3) begin
        for (int r = 29; r >= 0; r--) begin
          bv = '{1'b0, 1'b1, 1'b1, 8'(r)};
          apply_btn(bv);
        end
      end
      apply_btn(btab[k]);
    end

    // Next generation under rule 255 is all ones.
    wait_write(40, got);
    if (got) chk_write("rule255_gen1", 7'd1, 8'hFF, 16'd1);

    // 6. reset in the middle of that write cycle
    rst_n = 1'b0;
    #1;
    chk("midwr_wr_en", 16'(wr_en), 16'd0);
    chk("midwr_row", 16'(wr_row), 16'd0);
    chk("midwr_data", 16'(wr_data), 16'h10);
    chk("midwr_rule", 16'(rule), 16'd30);
    chk("midwr_gen", gen_count, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reseed_c1_wr_en", 16'(wr_en), 16'd0);
    @(negedge clk);
    chk("reseed_c2_wr_en", 16'(wr_en), 16'd1);
    chk_write("reseed", 7'd0, 8'h10, 16'd0);
    chk("reseed_rule", 16'(rule), 16'd30);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
